// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller sharing one BCD decoder across digits.
// Frame-synchronous value updates, blank gap before each digit for anti-ghosting.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [3:0]              bcd_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(DIV);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [0:0]            state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         active_d, pending_d;
  logic [NUM_DIGITS-1:0] active_dp, pending_dp;
  logic                  pend;

  logic                  slot_end, boundary, suppress;
  logic [CW-1:0]         cnt_nxt;
  logic [IW-1:0]         idx_nxt;
  logic [DW-1:0]         active_d_nxt;
  logic [NUM_DIGITS-1:0] active_dp_nxt;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  zero_run;

  assign slot_end   = (cnt == CNT_LAST);
  assign boundary   = slot_end && (idx == IDX_LAST);
  assign frame_done = boundary;
  assign cnt_nxt    = slot_end ? '0 : cnt + CW'(1);
  assign idx_nxt    = !slot_end ? idx : ((idx == IDX_LAST) ? '0 : idx + IW'(1));

  // A load on the boundary cycle bypasses pending so slot 0 of the next frame
  // already shows it; bcd_out is fed from this next-state view for that reason.
  always_comb begin
    active_d_nxt  = active_d;
    active_dp_nxt = active_dp;
    if (boundary && load) begin
      active_d_nxt  = din;
      active_dp_nxt = dp_in;
    end else if (boundary && pend) begin
      active_d_nxt  = pending_d;
      active_dp_nxt = pending_dp;
    end
  end

  // upper_zero[i] is set when digits i..NUM_DIGITS-1 are all zero.
  // NOTE: every combinational output gets a default before the loop; otherwise a latch is inferred.
  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (active_d[4*i +: 4] == 4'd0);
      upper_zero[i] = zero_run;
    end
  end

  assign suppress = lz_en && (idx != '0) && upper_zero[idx];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      idx        <= '0;
      active_d   <= '0;
      active_dp  <= '0;
      pending_d  <= '0;
      pending_dp <= '0;
      pend       <= 1'b0;
      bcd_out    <= '0;
      seg_out    <= '0;
      dp_out     <= 1'b0;
      dig_en     <= '0;
    end else begin
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      active_d  <= active_d_nxt;
      active_dp <= active_dp_nxt;

      if (boundary) begin
        pend <= 1'b0;
      end else if (load) begin
        pending_d  <= din;
        pending_dp <= dp_in;
        pend       <= 1'b1;
      end

      if (slot_end) begin
        bcd_out <= active_d_nxt[{idx_nxt, 2'b00} +: 4];
      end

      case (state)
        ST_BLANK: begin
          if (cnt == CNT_SAMPLE) begin
            state   <= ST_SHOW;
            seg_out <= suppress ? 7'd0 : seg_in;
            dp_out  <= active_dp[idx];
            dig_en  <= NUM_DIGITS'(1) << idx;
          end
        end
        default: begin
          if (slot_end) begin
            state   <= ST_BLANK;
            seg_out <= '0;
            dp_out  <= 1'b0;
            dig_en  <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit 7-segment display. It shares one combinational BCD-to-7-segment decoder across NUM_DIGITS digits. The block sequences the decoder input digit by digit, captures the decoder output, and drives the digit enables with an anti-ghosting blank gap. It sits between the counter/adder result registers and the board display pins. Display updates are frame-synchronous so the user never sees a half-updated value.

Parameters:
NUM_DIGITS, 4, number of display digits scanned (>=2)
DIV, 50000, clock cycles per digit slot, including the blank gap (DIV > BLANK_CYCLES)
BLANK_CYCLES, 2, cycles per slot with all digits off (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
load  in  1  single-cycle strobe: capture din/dp_in as the new display value
din  in  4*NUM_DIGITS  BCD digits; digit i = din[4i+3:4i], digit 0 = least significant
dp_in  in  NUM_DIGITS  decimal-point request per digit
lz_en  in  1  leading-zero suppression enable (level, sampled every cycle)
bcd_out  out  4  BCD code driven to the shared decoder input
seg_in  in  7  decoder output (segment pattern, bit0=a .. bit6=g, active-high)
seg_out  out  7  segment drive to the display, active-high
dp_out  out  1  decimal-point drive, active-high
dig_en  out  NUM_DIGITS  digit enable, one-hot active-high, or all zero during blank
frame_done  out  1  one-cycle pulse on the last cycle of every full scan frame

Behaviour:
- Registers: active value (din+dp), pending value, pend flag, digit index idx, slot counter cnt (0..DIV-1), phase state {BLANK, SHOW}.
- Reset (async, immediate): dig_en=0, seg_out=0, dp_out=0, bcd_out=0, frame_done=0, active=0, pending=0, pend=0, idx=0, cnt=0, state=BLANK. Reset mid-frame aborts the scan; the first cycle after release is slot 0, cnt=0.
- Slot timing: cnt increments every cycle. At cnt==DIV-1 it wraps to 0 and idx advances (NUM_DIGITS-1 wraps to 0).
- State BLANK while cnt<BLANK_CYCLES; state SHOW for cnt>=BLANK_CYCLES.
- BLANK: dig_en=0. bcd_out = active digit idx (registered, updated on the edge entering cnt=0). On the edge ending cnt==BLANK_CYCLES-1, seg_out<=seg_in (or 0 if suppressed) and dp_out<=dp bit idx.
- SHOW: dig_en = one-hot(idx). seg_out and dp_out hold their values. On the edge leaving SHOW, seg_out, dp_out and dig_en go to 0.
- Decoder latency: the decoder is treated as purely combinational. A full BLANK cycle separates a bcd_out change from the seg_in sample.
- Out-of-range digits (>9) pass through unchanged. The decoder returns 0, so the digit displays blank.
- Leading-zero suppression: digit i (i!=0) is suppressed when lz_en=1 and active digits i..NUM_DIGITS-1 are all 0. A suppressed digit has seg_out=0, but dp_out is still driven and dig_en still asserts. Digit 0 is never suppressed.
- load: captures din/dp_in into pending and sets pend. A later load before the frame boundary overwrites pending (last load wins).
- Frame boundary: the edge where idx wraps NUM_DIGITS-1 -> 0. If pend=1, active<=pending and pend<=0.
- load on the boundary cycle: din/dp_in are written directly into active, and pend is cleared.
- frame_done: 1 for exactly the cycle idx==NUM_DIGITS-1 and cnt==DIV-1; 0 otherwise.
- Frame period: NUM_DIGITS*DIV cycles, constant. load and lz_en never stall or skip the scan.

Test Plan:
Test parameters throughout: NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2. The bench models the decoder with the standard 0-9 patterns (0->0x3F ... 9->0x6F), else 0.
1. Reset release, no load -> each slot: 2 cycles dig_en=0000, then 6 cycles dig_en=0001/0010/0100/1000 in order with seg_out=0x3F. frame_done is high at cycles 31, 63, ...
2. load din=0x1234, dp_in=0100 at cycle 5 -> frame 0 still shows 0000. From cycle 32: slot0 seg=0x66, slot1 seg=0x4F, slot2 seg=0x5B with dp_out=1, slot3 seg=0x06.
3. load 0x1111 at cycle 40, then 0x9876 at cycle 50 -> from cycle 64 the display shows 9876; 1111 never appears.
4. load 0x0507 exactly at cycle 31 (boundary) -> slot 0 of frame 1 (cycle 32) already shows digit 7.
5. active=0x0050, lz_en=1 -> digit3 seg=0, digit2 seg=0, digit1 seg=0x6D, digit0 seg=0x3F. lz_en=0 -> digit3 and digit2 show 0x3F. active=0x0000, lz_en=1 -> only digit 0 shows 0x3F.
6. Assert rst at cycle 45 (mid-SHOW) -> all outputs 0 in the same cycle. After release, slot 0 restarts at cnt=0 with active=0 and no pending.
